reset_sequencer: RTL and testbench

Consumes the synchronized active-low reset produced by the reset generator in the target clock domain. Releases NUM_STAGES downstream reset domains one at a time, in index order, with a programmable hold and inter-stage delay. Stages flagged in ACK_MASK must return a ready acknowledge before the sequence advances; a missing acknowledge raises a fault. A software reset request restarts the whole sequence from any state.

---
 rtl/reset_sequencer.sv | 123 ++++++++++++
 tb/tb_reset_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Staged reset release for the target clock domain: hold, then release
// each downstream reset in index order with optional ready handshakes.
module reset_sequencer #(
    parameter int NUM_STAGES = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int STAGE_DELAY = 4,
    parameter int ACK_TIMEOUT = 64,
    parameter logic [NUM_STAGES-1:0] ACK_MASK = '0
) (
    input  logic                          target_clk,
    input  logic                          target_rst_n,
    input  logic                          sw_rst_req,
    input  logic [NUM_STAGES-1:0]         stage_ack,
    output logic [NUM_STAGES-1:0]         stage_rst_n,
    output logic                          seq_busy,
    output logic                          seq_done,
    output logic                          seq_fault,
    output logic [$clog2(NUM_STAGES)-1:0] fault_stage
);

    localparam int IDX_W = $clog2(NUM_STAGES);
    localparam int MAX_HD =
        (HOLD_CYCLES > STAGE_DELAY) ? HOLD_CYCLES : STAGE_DELAY;
    localparam int MAX_C =
        (MAX_HD > ACK_TIMEOUT) ? MAX_HD : ACK_TIMEOUT;
    localparam int CNT_W = $clog2(MAX_C) + 1;

    localparam logic [CNT_W-1:0] HOLD_T = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_T = CNT_W'(STAGE_DELAY - 1);
    localparam logic [CNT_W-1:0] ACK_T = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_STAGES - 1);

    typedef enum logic [2:0] {
        HOLD,
        RELEASE,
        WAIT_ACK,
        DELAY,
        DONE,
        FAULT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;

    assign seq_busy = (state == HOLD) || (state == RELEASE) ||
                      (state == WAIT_ACK) || (state == DELAY);
    assign seq_done = (state == DONE);

    always_ff @(posedge target_clk or negedge target_rst_n) begin
        if (!target_rst_n) begin
            state       <= HOLD;
            cnt         <= '0;
            idx         <= '0;
            stage_rst_n <= '0;
            seq_fault   <= 1'b0;
            fault_stage <= '0;
        end else if (sw_rst_req) begin
            // Restart wins over any ack or terminal count this edge
            state       <= HOLD;
            cnt         <= '0;
            idx         <= '0;
            stage_rst_n <= '0;
            seq_fault   <= 1'b0;
            fault_stage <= '0;
        end else begin
            unique case (state)
                HOLD: begin
                    if (cnt == HOLD_T) begin
                        state <= RELEASE;
                        cnt   <= '0;
                        idx   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    stage_rst_n[idx] <= 1'b1;
                    cnt              <= '0;
                    state <= ACK_MASK[idx] ? WAIT_ACK : DELAY;
                end
                WAIT_ACK: begin
                    if (stage_ack[idx]) begin
                        state <= DELAY;
                        cnt   <= '0;
                    end else if (cnt == ACK_T) begin
                        state       <= FAULT;
                        cnt         <= '0;
                        stage_rst_n <= '0;
                        seq_fault   <= 1'b1;
                        fault_stage <= idx;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DELAY: begin
                    if (cnt == DLY_T) begin
                        cnt <= '0;
                        if (idx == LAST) begin
                            state <= DONE;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= RELEASE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                FAULT: begin
                    state <= FAULT;
                end
                default: begin
                    state <= HOLD;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: release-time tables, handshake corners and
// random acks/restarts against a release-schedule model.
module tb_reset_sequencer;

    localparam int N = 4;
    localparam int HOLD = 8;
    localparam int DLY = 4;
    localparam int TMO = 64;
    localparam logic [N-1:0] MASK_B = 4'b0110;

    logic         target_clk = 1'b0;
    logic         target_rst_n = 1'b0;
    logic         sw_a = 1'b0;
    logic         sw_b = 1'b0;
    logic [N-1:0] ack_a = '0;
    logic [N-1:0] ack_b = '0;
    logic [N-1:0] rst_a, rst_b;
    logic         busy_a, done_a, fault_a;
    logic         busy_b, done_b, fault_b;
    logic [1:0]   fs_a, fs_b;

    int checks = 0;
    int errors = 0;

    always #5 target_clk = ~target_clk;

    reset_sequencer u_plain (
        .target_clk  (target_clk),
        .target_rst_n(target_rst_n),
        .sw_rst_req  (sw_a),
        .stage_ack   (ack_a),
        .stage_rst_n (rst_a),
        .seq_busy    (busy_a),
        .seq_done    (done_a),
        .seq_fault   (fault_a),
        .fault_stage (fs_a)
    );

    reset_sequencer #(.ACK_MASK(MASK_B)) u_mask (
        .target_clk  (target_clk),
        .target_rst_n(target_rst_n),
        .sw_rst_req  (sw_b),
        .stage_ack   (ack_b),
        .stage_rst_n (rst_b),
        .seq_busy    (busy_b),
        .seq_done    (done_b),
        .seq_fault   (fault_b),
        .fault_stage (fs_b)
    );

    // Schedule model for u_mask: release times per stage, relative to
    // the last restart, plus a pending-ack deadline for masked stages.
    int           m_t;
    int           m_rel [N];
    bit [N-1:0]   m_known;
    bit [N-1:0]   m_acked;
    bit           m_fault;
    int           m_fstage;
    int           m_done;

    function automatic void m_pass(int i, int p);
        int q;
        q = p;
        for (int j = i; j < N; j++) begin
            if (j == N - 1) begin
                m_done = q + DLY;
                break;
            end
            q = q + DLY + 1;
            m_rel[j+1] = q;
            m_known[j+1] = 1'b1;
            if (MASK_B[j+1]) break;
        end
    endfunction

    function automatic void model_reset();
        m_t = 0;
        m_known = '0;
        m_acked = '0;
        m_fault = 1'b0;
        m_fstage = 0;
        m_done = -1;
        for (int i = 0; i < N; i++) m_rel[i] = 0;
        m_rel[0] = HOLD + 1;
        m_known[0] = 1'b1;
        if (!MASK_B[0]) m_pass(0, HOLD + 1);
    endfunction

    function automatic void model_step();
        if (!target_rst_n || sw_b) begin
            model_reset();
        end else if (!m_fault) begin
            m_t++;
            for (int i = 0; i < N; i++) begin
                if (m_known[i] && MASK_B[i] && !m_acked[i]
                    && m_t > m_rel[i] && !m_fault) begin
                    if (ack_b[i]) begin
                        m_acked[i] = 1'b1;
                        m_pass(i, m_t);
                    end else if (m_t - m_rel[i] == TMO) begin
                        m_fault = 1'b1;
                        m_fstage = i;
                    end
                end
            end
        end
    endfunction

    function automatic logic [8:0] exp_b();
        logic [N-1:0] r;
        logic         d;
        r = '0;
        for (int i = 0; i < N; i++)
            r[i] = !m_fault && m_known[i] && (m_t >= m_rel[i]);
        d = !m_fault && (m_done >= 0) && (m_t >= m_done);
        return {r, !m_fault && !d, d, m_fault,
                m_fault ? 2'(m_fstage) : 2'b00};
    endfunction

    function automatic logic [8:0] obs_b();
        return {rst_b, busy_b, done_b, fault_b, fs_b};
    endfunction

    task automatic check(string name, logic [15:0] act,
                         logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge target_clk);
        model_step();
        #2;
        check("model", 16'(obs_b()), 16'(exp_b()));
    endtask

    typedef struct {
        int           edge_n;
        logic [N-1:0] rst;
        logic         busy;
        logic         done;
    } vec_t;

    vec_t tbl [12];

    task automatic run_table(string tag);
        for (int e = 1; e <= 30; e++) begin
            tick();
            for (int k = 0; k < 12; k++) begin
                if (tbl[k].edge_n == e)
                    check($sformatf("%s_e%0d", tag, e),
                          16'({rst_a, busy_a, done_a, fault_a, fs_a}),
                          16'({tbl[k].rst, tbl[k].busy, tbl[k].done,
                               1'b0, 2'b00}));
            end
        end
    endtask

    task automatic pulse_b();
        sw_b = 1'b1;
        tick();
        sw_b = 1'b0;
    endtask

    initial begin
        int pct;
        tbl[0]  = '{1,  4'b0000, 1'b1, 1'b0};
        tbl[1]  = '{8,  4'b0000, 1'b1, 1'b0};
        tbl[2]  = '{9,  4'b0001, 1'b1, 1'b0};
        tbl[3]  = '{13, 4'b0001, 1'b1, 1'b0};
        tbl[4]  = '{14, 4'b0011, 1'b1, 1'b0};
        tbl[5]  = '{18, 4'b0011, 1'b1, 1'b0};
        tbl[6]  = '{19, 4'b0111, 1'b1, 1'b0};
        tbl[7]  = '{23, 4'b0111, 1'b1, 1'b0};
        tbl[8]  = '{24, 4'b1111, 1'b1, 1'b0};
        tbl[9]  = '{27, 4'b1111, 1'b1, 1'b0};
        tbl[10] = '{28, 4'b1111, 1'b0, 1'b1};
        tbl[11] = '{30, 4'b1111, 1'b0, 1'b1};
        model_reset();

        repeat (3) tick();
        check("reset_a", 16'({rst_a, busy_a, done_a, fault_a, fs_a}),
              16'({4'b0000, 1'b1, 1'b0, 1'b0, 2'b00}));
        check("reset_b", 16'(obs_b()),
              16'({4'b0000, 1'b1, 1'b0, 1'b0, 2'b00}));
        target_rst_n = 1'b1;
        run_table("por");

        // Restart from DONE
        sw_a = 1'b1;
        tick();
        sw_a = 1'b0;
        check("sw_done_clr", 16'({rst_a, busy_a, done_a}),
              16'({4'b0000, 1'b1, 1'b0}));
        run_table("sw_done");

        // Restart from DELAY right after stage 1 release
        sw_a = 1'b1;
        tick();
        sw_a = 1'b0;
        repeat (15) tick();
        check("delay_pre", 16'(rst_a), 16'(4'b0011));
        sw_a = 1'b1;
        tick();
        sw_a = 1'b0;
        check("delay_sw", 16'({rst_a, busy_a}), 16'(5'b00001));
        run_table("sw_delay");

        // Late ack on masked stage 1 stretches the release gap
        ack_b = '0;
        pulse_b();
        for (int e = 1; e <= 40; e++) begin
            tick();
            if (e == 14) check("b_s1_rel", 16'(rst_b), 16'(4'b0011));
            if (e == 29) check("b_gap_pre", 16'(rst_b), 16'(4'b0011));
            if (e == 30)
                check("b_gap_rel", 16'({rst_b, fault_b}),
                      16'({4'b0111, 1'b0}));
            if (e == 40)
                check("b_done", 16'({done_b, busy_b, fault_b}),
                      16'(3'b100));
            if (e == 24) ack_b = 4'b0010;
            if (e == 25) ack_b = 4'b0110;
        end

        // Asynchronous reset while waiting for an ack
        ack_b = '0;
        pulse_b();
        repeat (17) tick();
        #2;
        target_rst_n = 1'b0;
        #1;
        check("async_b", 16'(obs_b()),
              16'({4'b0000, 1'b1, 1'b0, 1'b0, 2'b00}));
        check("async_a", 16'({rst_a, busy_a, done_a}),
              16'({4'b0000, 1'b1, 1'b0}));
        tick();
        tick();
        target_rst_n = 1'b1;
        ack_b = 4'b0110;
        repeat (40) tick();
        check("async_done", 16'({done_a, done_b, fault_b}),
              16'(3'b110));

        // Ack timeout on stage 2, then recovery by software request
        ack_b = 4'b0010;
        pulse_b();
        for (int e = 1; e <= 94; e++) begin
            tick();
            if (e == 83)
                check("tmo_pre", 16'({rst_b, fault_b}),
                      16'({4'b0111, 1'b0}));
            if (e == 84 || e == 94)
                check($sformatf("tmo_e%0d", e), 16'(obs_b()),
                      16'({4'b0000, 1'b0, 1'b0, 1'b1, 2'd2}));
        end
        pulse_b();
        check("tmo_clr", 16'({fault_b, fs_b, busy_b}),
              16'({1'b0, 2'b00, 1'b1}));
        ack_b = 4'b1111;
        repeat (40) tick();
        check("tmo_recover", 16'({rst_b, done_b, fault_b}),
              16'({4'b1111, 1'b1, 1'b0}));

        // Random acks, restarts and async resets
        pct = 30;
        for (int c = 0; c < 4000; c++) begin
            if (c % 128 == 0) begin
                case ($urandom_range(0, 2))
                    0: pct = 0;
                    1: pct = 2;
                    default: pct = 30;
                endcase
            end
            for (int i = 0; i < N; i++)
                ack_b[i] = ($urandom_range(0, 99) < pct);
            sw_b = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 999) == 0) target_rst_n = 1'b0;
            else target_rst_n = 1'b1;
            tick();
        end
        sw_b = 1'b0;
        target_rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
